bcd_stopwatch: RTL and testbench

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_stopwatch.sv | 139 +++++++++++++
 tb/tb_bcd_stopwatch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the BCD stopwatch: BCD digit width and the
// active-low seven-segment patterns (bit 7 = decimal point, always off).
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 never occur on a legal count; they blank the digit.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [SEG_W-1:0] seg
);

  // digit -> segment pattern lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD up/down stopwatch with registered seven-segment outputs.
// A prescaler divides ADC_CLK_10 by TICK_DIV; each tick steps the BCD count
// up or down (dir sampled on the tick edge), wrapping with a one-cycle tc.
// Optional macro LAP_HOLD_EN: lap rising edges toggle a display hold that
// freezes hex on a snapshot while count_bcd keeps running.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int TICK_DIV = 10000
) (
  input  logic                      ADC_CLK_10,
  input  logic                      KEY0,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      clr,
  input  logic                      lap,
  output logic [BCD_W*N_DIGITS-1:0] count_bcd,
  output logic [SEG_W*N_DIGITS-1:0] hex,
  output logic                      tc
);

  localparam int              PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int              CNT_W    = BCD_W * N_DIGITS;

  logic [PRE_W-1:0]          presc;
  logic                      tick;
  logic [CNT_W-1:0]          cnt_up;
  logic [CNT_W-1:0]          cnt_dn;
  logic                      wrap_up;
  logic                      wrap_dn;
  logic [CNT_W-1:0]          disp;
  logic [SEG_W*N_DIGITS-1:0] seg_live;

  assign tick = en & ~clr & (presc == PRE_LAST);

  // prescaler: free-runs while enabled, clr and reset abandon a partial period
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == PRE_LAST) presc <= '0;
      else                   presc <= presc + 1'b1;
    end
  end

  // ripple-carry BCD increment and ripple-borrow decrement of the live count
  always_comb begin
    cnt_up  = count_bcd;
    cnt_dn  = count_bcd;
    wrap_up = 1'b1;
    wrap_dn = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (wrap_up) begin
        if (count_bcd[i*BCD_W +: BCD_W] >= BCD_MAX) begin
          cnt_up[i*BCD_W +: BCD_W] = '0;
        end else begin
          cnt_up[i*BCD_W +: BCD_W] = count_bcd[i*BCD_W +: BCD_W] + 4'd1;
          wrap_up = 1'b0;
        end
      end
      if (wrap_dn) begin
        if (count_bcd[i*BCD_W +: BCD_W] == 4'd0) begin
          cnt_dn[i*BCD_W +: BCD_W] = BCD_MAX;
        end else if (count_bcd[i*BCD_W +: BCD_W] > BCD_MAX) begin
          cnt_dn[i*BCD_W +: BCD_W] = BCD_MAX - 4'd1;
          wrap_dn = 1'b0;
        end else begin
          cnt_dn[i*BCD_W +: BCD_W] = count_bcd[i*BCD_W +: BCD_W] - 4'd1;
          wrap_dn = 1'b0;
        end
      end
    end
  end

  // count register and wrap pulse; clr outranks tick
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      count_bcd <= '0;
      tc        <= 1'b0;
    end else if (clr) begin
      count_bcd <= '0;
      tc        <= 1'b0;
    end else if (tick) begin
      count_bcd <= dir ? cnt_up : cnt_dn;
      tc        <= dir ? wrap_up : wrap_dn;
    end else begin
      tc        <= 1'b0;
    end
  end

`ifdef LAP_HOLD_EN
  logic             lap_q;
  logic             hold;
  logic [CNT_W-1:0] snap;

  // registered lap for rising-edge detection
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) lap_q <= 1'b0;
    else       lap_q <= lap;
  end

  // hold toggles on each lap rising edge; entering hold captures the count
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (clr) begin
      hold <= 1'b0;
    end else if (lap && !lap_q) begin
      hold <= ~hold;
      if (!hold) snap <= count_bcd;
    end
  end

  assign disp = hold ? snap : count_bcd;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = count_bcd;
`endif

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
    seg7_decode u_dec (
      .digit (disp[g*BCD_W +: BCD_W]),
      .seg   (seg_live[g*SEG_W +: SEG_W])
    );
  end

  // display register: one cycle behind the displayed value
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) hex <= {N_DIGITS{SEG_0}};
    else       hex <= seg_live;
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (N_DIGITS=2, TICK_DIV=4).
// Lap-hold scenarios are included when LAP_HOLD_EN is defined.
module tb_bcd_stopwatch;

  localparam int ND = 2;
  localparam int TD = 4;

  logic        clk  = 1'b0;
  logic        key0 = 1'b0;
  logic        en   = 1'b0;
  logic        dir  = 1'b0;
  logic        clr  = 1'b0;
  logic        lap  = 1'b0;
  logic [7:0]  count_bcd;
  logic [15:0] hex;
  logic        tc;

  bcd_stopwatch #(.N_DIGITS(ND), .TICK_DIV(TD)) dut (
    .ADC_CLK_10 (clk),
    .KEY0       (key0),
    .en         (en),
    .dir        (dir),
    .clr        (clr),
    .lap        (lap),
    .count_bcd  (count_bcd),
    .hex        (hex),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_hex(int v);
    return {seg_tab[v / 10], seg_tab[v % 10]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: count as an integer 0..99, prescaler as an integer
  int          m_cnt  = 0;
  int          m_pre  = 0;
  int          m_snap = 0;
  bit          m_tc   = 1'b0;
  bit          m_lap_q = 1'b0;
  bit          m_hold = 1'b0;
  logic [15:0] m_hex  = 16'hC0C0;

  always @(posedge clk or negedge key0) begin
    if (!key0) begin
      m_cnt = 0; m_pre = 0; m_tc = 1'b0; m_hex = 16'hC0C0;
      m_lap_q = 1'b0; m_hold = 1'b0; m_snap = 0;
    end else begin
      int disp;
      disp = m_cnt;
`ifdef LAP_HOLD_EN
      if (m_hold) disp = m_snap;
      if (clr) m_hold = 1'b0;
      else if (lap && !m_lap_q) begin
        if (!m_hold) m_snap = m_cnt;
        m_hold = !m_hold;
      end
      m_lap_q = lap;
`endif
      m_hex = to_hex(disp);
      m_tc  = 1'b0;
      if (clr) begin
        m_cnt = 0;
        m_pre = 0;
      end else if (en) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          if (dir) begin
            m_tc  = (m_cnt == 99);
            m_cnt = (m_cnt + 1) % 100;
          end else begin
            m_tc  = (m_cnt == 0);
            m_cnt = (m_cnt + 99) % 100;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
      check("tc",    32'(tc),        32'(m_tc));
      check("hex",   32'(hex),       32'(m_hex));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_count", 32'(count_bcd), 32'h00);
    check("rst_hex",   32'(hex),       32'hC0C0);
    check("rst_tc",    32'(tc),        32'h0);

    // up-count 40 cycles
    @(negedge clk);
    key0 = 1'b1; en = 1'b1; dir = 1'b1;
    repeat (40) @(negedge clk);
    check("up40_count", 32'(count_bcd), 32'h10);
    @(negedge clk);
    check("up40_hex", 32'(hex), 32'hF9C0);

    // down wrap 00 -> 99, then up wrap 99 -> 00
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; dir = 1'b0;
    repeat (4) @(negedge clk);
    check("dn_wrap_count", 32'(count_bcd), 32'h99);
    check("dn_wrap_tc",    32'(tc),        32'h1);
    @(negedge clk);
    check("dn_wrap_tc_off", 32'(tc), 32'h0);
    dir = 1'b1;
    repeat (3) @(negedge clk);
    check("up_wrap_count", 32'(count_bcd), 32'h00);
    check("up_wrap_tc",    32'(tc),        32'h1);
    @(negedge clk);
    check("up_wrap_tc_off", 32'(tc), 32'h0);

    // clr on the tick cycle at 37
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (148) @(negedge clk);
    check("at37", 32'(count_bcd), 32'h37);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_count", 32'(count_bcd), 32'h00);
    check("clr_tc",    32'(tc),        32'h0);
    repeat (3) @(negedge clk);
    check("clr_pre0_a", 32'(count_bcd), 32'h00);
    @(negedge clk);
    check("clr_pre0_b", 32'(count_bcd), 32'h01);

    // pause, then async reset mid-prescaler
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("pause", 32'(count_bcd), 32'h01);
    en = 1'b1;
    repeat (2) @(negedge clk);
    #2 key0 = 1'b0;
    #1;
    check("async_count", 32'(count_bcd), 32'h00);
    check("async_hex",   32'(hex),       32'hC0C0);
    check("async_tc",    32'(tc),        32'h0);
    @(negedge clk);
    key0 = 1'b1;
    repeat (3) @(negedge clk);
    check("resume_a", 32'(count_bcd), 32'h00);
    @(negedge clk);
    check("resume_b", 32'(count_bcd), 32'h01);

`ifdef LAP_HOLD_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    check("lap_at05", 32'(count_bcd), 32'h05);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    repeat (31) @(negedge clk);
    check("lap_count", 32'(count_bcd), 32'h13);
    check("lap_hex",   32'(hex),       32'hC092);
    en  = 1'b0;
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    repeat (2) @(negedge clk);
    check("lap_release_hex", 32'(hex), 32'hF9B0);
`endif

    // randomized run against the model
    repeat (4000) @(negedge clk) begin
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 299) == 0);
      lap = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) dir = ~dir;
      if ($urandom_range(0, 599) == 0) begin
        #2 key0 = 1'b0;
        @(negedge clk);
        key0 = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
